// File: rtl/multibank_pkg.sv
// Shared types for the multibank request front-end: FSM states, request
// record and the bank-select width helper.
package multibank_pkg;

  // Word and address widths of the multibank macro this front-end drives.
  localparam int MB_DATA_W = 32;
  localparam int MB_ADDR_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [MB_ADDR_W-1:0] addr;
    logic [MB_DATA_W-1:0] wdata;
  } req_t;

  // Bits needed to select one of n banks; never less than one.
  function automatic int bank_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multibank_fifo.sv
// Synchronous FIFO with full/empty/count. DEPTH must be a power of two so
// the pointers wrap naturally. Pushes while full and pops while empty are
// dropped.
module multibank_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so dout reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/multibank_req_ctrl.sv
// Request front-end for the multibank SRAM wrapper: buffers requests, issues
// them in order on registered memory pins, returns read data in order through
// a credit-protected response FIFO, and drains on quiesce.
// Optional build macro MULTIBANK_REQ_CTRL_STATS_EN adds saturating read/write
// issue counters on ports stat_rd_cnt / stat_wr_cnt.
//
// state | meaning
// RUN   | accept and issue
// DRAIN | no accept; issue what is queued, wait for in-flight reads
// HALT  | nothing outstanding, idle=1
module multibank_req_ctrl
  import multibank_pkg::*;
#(
  parameter int DATA_WIDTH   = MB_DATA_W,
  parameter int ADDR_WIDTH   = MB_ADDR_W,
  parameter int NUM_BANKS    = 2,
  parameter int REQ_DEPTH    = 4,
  parameter int RSP_DEPTH    = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  quiesce,
  output logic                  idle,
  output logic                  mem_csb,
  output logic                  mem_web,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef MULTIBANK_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_wr_cnt
`endif
);

  localparam int BANK_W = bank_sel_width(NUM_BANKS);
  localparam int REQ_CW = $clog2(REQ_DEPTH) + 1;
  localparam int CRW    = $clog2(RSP_DEPTH) + 1;
  localparam logic [CRW-1:0] CREDIT_MAX = CRW'(RSP_DEPTH);

  state_t state;
  state_t state_next;

  logic              ready_en;
  req_t              req_in;
  req_t              req_head;
  logic              req_push;
  logic              req_pop;
  logic              req_full;
  logic              req_empty;
  logic [REQ_CW-1:0] req_count;

  logic              rsp_push;
  logic              rsp_pop;
  logic              rsp_full;
  logic              rsp_empty;
  logic [CRW-1:0]    rsp_count;

  logic [CRW-1:0]          credits;
  logic                    pop_q;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic                    issue;
  logic                    rd_issue;
  logic                    mem_rd_now;
  logic                    rd_inflight;

  // ready_en keeps req_ready low while reset is asserted, even though the
  // state and FIFO would otherwise allow acceptance.
  assign req_ready = ready_en && (state == RUN) && !req_full;
  assign req_push  = req_valid && req_ready;
  assign req_in    = {req_we, req_addr, req_wdata};

  // Writes never consume a credit; reads need room reserved in the response FIFO.
  assign issue    = !req_empty && (state != HALT) && (req_head.we || (credits < CREDIT_MAX));
  assign req_pop  = issue;
  assign rd_issue = issue && !req_head.we;

  // The registered memory pins form stage zero of the read tracker.
  assign mem_rd_now  = !mem_csb && mem_web;
  assign rd_inflight = mem_rd_now || (|rd_pipe);
  assign rsp_push    = rd_pipe[READ_LATENCY-1];

  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  multibank_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_push),
    .din   (req_in),
    .pop   (req_pop),
    .dout  (req_head),
    .full  (req_full),
    .empty (req_empty),
    .count (req_count)
  );

  multibank_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .din   (mem_dout),
    .pop   (rsp_pop),
    .dout  (rsp_rdata),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (quiesce) state_next = DRAIN;
      end
      DRAIN: begin
        if (!quiesce)                        state_next = RUN;
        else if (req_empty && !rd_inflight)  state_next = HALT;
      end
      HALT: begin
        if (!quiesce) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Acceptance enable and idle flag, both registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      idle     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      idle     <= (state_next == HALT);
    end
  end

  // Memory pin registers: one-cycle strobe per issue, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_csb  <= 1'b1;
      mem_web  <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (issue) begin
      mem_csb  <= 1'b0;
      mem_web  <= ~req_head.we;
      mem_addr <= req_head.addr;
      mem_din  <= req_head.wdata;
    end else begin
      mem_csb  <= 1'b1;
      mem_web  <= 1'b1;
    end
  end

  // Read tracker: tail lines up with the cycle mem_dout is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= mem_rd_now;
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Credits: reads in flight plus response occupancy; release lags the pop by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= '0;
      pop_q   <= 1'b0;
    end else begin
      pop_q   <= rsp_pop;
      credits <= credits + CRW'(rd_issue) - CRW'(pop_q);
    end
  end

`ifdef MULTIBANK_REQ_CTRL_STATS_EN
  // Saturating issue counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      if (rd_issue && (stat_rd_cnt != 16'hFFFF))
        stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (issue && req_head.we && (stat_wr_cnt != 16'hFFFF))
        stat_wr_cnt <= stat_wr_cnt + 16'd1;
    end
  end
`endif

  // A capture into a full response FIFO means the credit accounting is broken.
  a_rsp_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    rsp_push |-> !rsp_full);

  // Credits always cover everything already sitting in the response FIFO.
  a_credit_cover : assert property (@(posedge clk) disable iff (!rst_n)
    rsp_count <= credits);

  a_req_bound : assert property (@(posedge clk) disable iff (!rst_n)
    req_count <= REQ_CW'(REQ_DEPTH));

  // Bank select must fit in the address, and the request record must match the pins.
  a_geometry : assert property (@(posedge clk) disable iff (!rst_n)
    (BANK_W <= ADDR_WIDTH) && (ADDR_WIDTH == MB_ADDR_W) && (DATA_WIDTH == MB_DATA_W));

endmodule

// File: tb/tb_multibank_req_ctrl.sv
// Bench for multibank_req_ctrl: behavioural SRAM, reference memory image and
// expected-issue / expected-response queues checked by a free-running monitor.
module tb_multibank_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        quiesce, idle;
  logic        mem_csb, mem_web;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
`ifdef MULTIBANK_REQ_CTRL_STATS_EN
  logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif

  always #5 clk = ~clk;

  multibank_req_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .quiesce   (quiesce),
    .idle      (idle),
    .mem_csb   (mem_csb),
    .mem_web   (mem_web),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
`ifdef MULTIBANK_REQ_CTRL_STATS_EN
    ,
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
`endif
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A50000 ^ (32'(i) * 32'h00010203);
  endfunction

  // Behavioural SRAM: 2-cycle read latency; dout is random when not valid.
  logic        sram_clr;
  logic [31:0] sram [256];
  logic        rd_v1;
  logic [31:0] rd_d1;
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
    end else if (!mem_csb && !mem_web) begin
      sram[mem_addr] <= mem_din;
    end
    rd_v1    <= !mem_csb && mem_web;
    rd_d1    <= sram[mem_addr];
    mem_dout <= rd_v1 ? rd_d1 : $urandom;
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } iss_t;

  iss_t        exp_iss[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] mem_ref [256];
  int checks = 0;
  int errors = 0;
  int n_rd_iss = 0;
  int n_rsp = 0;
  bit rnd_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor: every memory strobe and every response pop is matched against the queues.
  initial begin
    iss_t e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!mem_csb) begin
          if (exp_iss.size() == 0) begin
            fail_now("unexpected_issue");
          end else begin
            e = exp_iss.pop_front();
            chk("iss_web", mem_web, !e.we);
            chk("iss_addr", mem_addr, e.addr);
            if (e.we) chk("iss_din", mem_din, e.data);
            if (mem_web) n_rd_iss++;
          end
        end
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          if (exp_rsp.size() == 0) begin
            fail_now("unexpected_rsp");
          end else begin
            d = exp_rsp.pop_front();
            chk("rsp_rdata", rsp_rdata, d);
          end
        end
      end
    end
  end

  // Offer one request until accepted or max_cyc expires; model updated at acceptance.
  task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d,
                      input int max_cyc);
    iss_t e;
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      fail_now("req_accept");
    end else begin
      e.we = we; e.addr = a; e.data = d;
      exp_iss.push_back(e);
      if (we) mem_ref[a] = d;
      else    exp_rsp.push_back(mem_ref[a]);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    rsp_ready = 1'b1;
    while ((exp_rsp.size() != 0 || exp_iss.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail_now(name);
    else checks++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_idle"},      idle, 0);
    chk({tag, "_mem_csb"},   mem_csb, 1);
    chk({tag, "_mem_web"},   mem_web, 1);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_din"},   mem_din, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_rsp, lat, n, seen;
    logic [7:0] a;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; quiesce = 0; sram_clr = 1;
    for (int i = 0; i < 256; i++) mem_ref[i] = init_val(i);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    sram_clr = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", req_ready, 1);

    // Write then read the same address: issue timing and read latency
    rsp_ready = 1'b0;
    send(1'b1, 8'h05, 32'hDEADBEEF, 10);
    @(posedge clk);
    #1;
    chk("wr_csb_next_cycle", mem_csb, 0);
    chk("wr_web_next_cycle", mem_web, 0);
    send(1'b0, 8'h05, $urandom, 10);
    @(posedge clk);
    #1;
    chk("rd_csb_next_cycle", mem_csb, 0);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rd_latency", lat, 4);
    chk("rd_after_wr_data", rsp_rdata, 32'hDEADBEEF);
    drain("drain_t1");

    // Burst of 8 reads with the consumer stalled: credit limit then release
    base = n_rd_iss;
    base_rsp = n_rsp;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i), $urandom, 20);
    repeat (6) @(posedge clk);
    #1;
    chk("credit_stall_issued", n_rd_iss - base, 4);
    chk("credit_stall_csb", mem_csb, 1);
    @(negedge clk);
    chk("full_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    drain("drain_burst");
    chk("burst_issued_total", n_rd_iss - base, 8);
    chk("burst_rsp_total", n_rsp - base_rsp, 8);

    // Bank boundary 0x7F / 0x80
    rsp_ready = 1'b1;
    send(1'b1, 8'h7F, 32'h1111_7F7F, 10);
    send(1'b1, 8'h80, 32'h2222_8080, 10);
    send(1'b0, 8'h7F, 0, 10);
    send(1'b0, 8'h80, 0, 10);
    drain("drain_bank");

    // Quiesce with 3 reads queued behind a full credit window
    rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(1'b0, 8'h10 + 8'(i), 0, 20);
    quiesce = 1'b1;
    @(posedge clk);
    #1;
    chk("quiesce_req_ready", req_ready, 0);
    chk("quiesce_not_idle", idle, 0);
    rsp_ready = 1'b1;
    n = 0;
    while (!idle && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) fail_now("idle_wait");
    else checks++;
    chk("idle_all_issued", exp_iss.size(), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("idle_all_returned", exp_rsp.size(), 0);
    chk("idle_held", idle, 1);
    quiesce = 1'b0;
    @(posedge clk);
    #1;
    chk("unquiesce_idle", idle, 0);
    chk("unquiesce_ready", req_ready, 1);

    // Reset while reads are in flight
    rsp_ready = 1'b1;
    send(1'b0, 8'h21, 0, 10);
    send(1'b0, 8'h22, 0, 10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_iss.delete();
    exp_rsp.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    @(posedge clk);
    #1;
    send(1'b0, 8'h22, 0, 10);
    drain("drain_post_reset");

    // Randomized traffic around the bank boundary with a jittery consumer
    rnd_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = 8'h7C + 8'($urandom_range(0, 7));
      send(1'($urandom_range(0, 1)), a, $urandom, 60);
      if ($urandom_range(0, 3) == 0) begin
        rsp_ready = ($urandom_range(0, 1) != 0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
